// File: rtl/cdb_arbiter_pkg.sv
// Shared completion-stage types and constants for the CDB arbiter and its per-FU FIFOs.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_FU       = 3;
    localparam int CDB_FIFO_DEPTH   = 8;
    localparam int CDB_STALL_MARGIN = 4;
    localparam int TAG_W            = 6;
    localparam int XLEN             = 32;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_BR   = 2'd2
    } CDB_FU_IDX;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             take_branch;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } EX_CP_PACKET;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-FU completion FIFO; a push into a full FIFO is taken only when the head pops in the same cycle.
module cp_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  EX_CP_PACKET push_packet,
    output EX_CP_PACKET head_packet,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    EX_CP_PACKET   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign head_packet = mem[head];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // Storage is not reset; the arbiter masks the head whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[tail] <= push_packet;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: buffers FU results per FU and broadcasts one per cycle on the CDB, round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU       = CDB_NUM_FU,
    parameter int FIFO_DEPTH   = CDB_FIFO_DEPTH,
    parameter int STALL_MARGIN = CDB_STALL_MARGIN
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              squash_in,
    input  EX_CP_PACKET       fu_packet_in [NUM_FU],
    output EX_CP_PACKET       cdb_packet_out,
    output logic [NUM_FU-1:0] cdb_grant_out,
    output logic [NUM_FU-1:0] fu_stall_out,
    output logic              overflow_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     win_idx;
    logic              win_found;
    logic              grant_any;
    EX_CP_PACKET       head_pkt [NUM_FU];
    logic [AW:0]       count    [NUM_FU];
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] push_req;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] drop;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign push_req[g] = fu_packet_in[g].valid && fu_packet_in[g].done && !squash_in;
        assign pop[g]      = cdb_grant_out[g];
        assign drop[g]     = push_req[g] && full[g] && !pop[g];
        // Stall leaves room for every op already inside the deepest non-stallable pipeline.
        assign fu_stall_out[g] = (FIFO_DEPTH - int'(count[g])) <= STALL_MARGIN;

        cp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .push        (push_req[g]),
            .pop         (pop[g]),
            .flush       (squash_in),
            .push_packet (fu_packet_in[g]),
            .head_packet (head_pkt[g]),
            .count       (count[g]),
            .full        (full[g]),
            .empty       (empty[g])
        );
    end

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!win_found && !empty[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    assign grant_any      = win_found && !squash_in;
    assign cdb_grant_out  = grant_any ? ((NUM_FU)'(1) << win_idx) : '0;
    assign cdb_packet_out = grant_any ? head_pkt[win_idx] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (grant_any) rr_ptr <= PW'(rr_next(int'(win_idx), NUM_FU));
            if (|drop)     overflow_err <= 1'b1;
        end
    end

    drop_check: assert property (@(posedge clock) disable iff (reset) drop == '0)
        else $warning("cdb_arbiter: completed packet dropped on a full FU FIFO");

endmodule
